mux4way16_arbiter: RTL and testbench
====================================

// Module: mux4way16_arbiter
// PURPOSE
//   Shares one 16-bit output channel between four requesters (a, b, c, d) using round-robin arbitration.
//   Drives the select of an internal mux4way16 and registers the winning word.
//   Presents the word on a valid/ready output handshake.
//   Sits between four producer blocks and a single downstream consumer, such as a register-file write port.
// PARAMETERS
//   WIDTH    16  data width of each requester and of out
//   RR_MODE  1   1 = round-robin priority; 0 = fixed priority (a > b > c > d)
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   req        in   4      req[0]=a .. req[3]=d; level request, held until acked
//   a,b,c,d    in   WIDTH  requester data; must be stable while its req is high
//   ack        out  4      one-hot; ack[i]=1 in the cycle a/b/c/d[i] is captured
//   sel        out  2      index of the last granted requester (registered)
//   out        out  WIDTH  captured word (registered)
//   out_valid  out  1      out holds a word not yet accepted
//   out_ready  in   1      consumer accepts out when out_valid && out_ready
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - state=IDLE, out_valid=0, out=0, sel=2'b11, ptr=2'b11 (so requester a wins first); ack forced 0.
//     - Any pending word is discarded, with no ack replay.
//   States:
//     - IDLE: out_valid=0.
//     - FULL: out_valid=1, out/sel stable.
//   load = |req && (state==IDLE || out_ready).
//     Evaluated combinationally from the current state and inputs.
//   Winner, RR_MODE=1: first i with req[i]=1, scanning from (ptr+1) mod 4 upward and wrapping 3->0.
//   Winner, RR_MODE=0: lowest i with req[i]=1.
//   ack = load ? onehot(winner) : 4'b0000. Combinational, at most one bit set.
//   On an edge with load:
//     - out <= mux(winner); sel <= winner; ptr <= winner; state <= FULL.
//   Data is captured on the edge ending the ack cycle; ack-to-out_valid latency is 1 cycle.
//   Transitions:
//     - IDLE -> FULL on load.
//     - FULL -> IDLE on out_ready && !|req.
//     - FULL -> FULL on out_ready && |req: back-to-back, one word per cycle, no bubble.
//   FULL && !out_ready: no ack, out/sel/ptr frozen.
//     - req may change freely; only the request state at the accepting cycle matters.
//   Simultaneous requests: exactly one ack per load. The others stay pending.
//   Fairness: under RR_MODE=1 a continuously requesting i is granted within 4 loads.
//   ptr advances only on load; a stalled consumer does not rotate priority.
//   A requester dropping req before its ack loses nothing and is simply not granted.
//   Width: out is exactly WIDTH bits; no extension or truncation.
// STRUCTURE
//   Shared package:
//     - state enum {IDLE, FULL}.
//     - requester index constants REQ_A=0..REQ_D=3.
//     - reset values SEL_RST=2'b11, PTR_RST=2'b11.
//   Sub-module: one mux4way16 instance.
//     - sel input = combinational winner; output feeds the out register.
//   Winner logic is a 4-input rotate / priority-encode / rotate-back within this module.
// TESTING
//   1. Hold rst_n=0 with req=4'b1111 -> ack=0, out_valid=0, out=0, sel=11.
//   2. Release reset with req=4'b0001, a=16'h1234 -> ack=0001 that cycle.
//      Next cycle out_valid=1, out=16'h1234, sel=00.
//   3. RR rotation: req=1111 held, out_ready=1 constantly.
//      Data a=16'h1234, b=16'h9876, c=16'hAAAA, d=16'h5555.
//      -> acks 0001,0010,0100,1000,0001.
//      -> out sequence 1234,9876,AAAA,5555,1234 on consecutive cycles.
//   4. Backpressure: out_valid=1 with out=16'h9876, out_ready=0 for 3 cycles, req=0100.
//      -> ack=0 and out stable throughout.
//      -> On the cycle out_ready=1, ack=0100; next cycle out=16'hAAAA.
//   5. RR_MODE=0 with req=1010 held and out_ready=1 -> ack=0010 every cycle; d is never granted.
//   6. Reset mid-operation: drop rst_n while out_valid=1 and out=16'h5555.
//      -> out_valid=0 and out=0 immediately, without waiting for a clock edge.
//      -> After release with req=1000, ack=1000 (ptr reset makes a first, d is the only requester).

Source files
------------

// File: rtl/mux4way16_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mux4way16_arbiter_pkg
//   Shared types and constants for the four-requester 16-bit arbiter slice.
//   - state_t       : output channel state (IDLE = empty, FULL = word held)
//   - REQ_A..REQ_D  : requester indices, also the mux select encoding
//   - SEL_RST       : reset value of the registered select
//   - PTR_RST       : reset value of the round-robin pointer; 3 makes a win first
//   - onehot4()     : index -> one-hot ack vector
// ---------------------------------------------------------------------------
package mux4way16_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  localparam logic [1:0] REQ_A = 2'd0;
  localparam logic [1:0] REQ_B = 2'd1;
  localparam logic [1:0] REQ_C = 2'd2;
  localparam logic [1:0] REQ_D = 2'd3;

  localparam logic [1:0] SEL_RST = 2'b11;
  localparam logic [1:0] PTR_RST = 2'b11;

  // Turns a requester index into the matching one-hot ack pattern.
  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] vec;
    vec      = 4'b0000;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/mux4way16_arbiter_mux.sv
// ---------------------------------------------------------------------------
// mux4way16
//   Plain four-way word multiplexer.
//   Ports:
//     sel        in  2      which input to pass (REQ_A..REQ_D)
//     a,b,c,d    in  WIDTH  candidate words
//     out        out WIDTH  selected word
// ---------------------------------------------------------------------------
module mux4way16
  import mux4way16_arbiter_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] out
);

  // Select one of the four words; d covers the last encoding.
  always_comb begin
    out = d;
    case (sel)
      REQ_A:   out = a;
      REQ_B:   out = b;
      REQ_C:   out = c;
      default: out = d;
    endcase
  end

endmodule

// File: rtl/mux4way16_arbiter.sv
// ---------------------------------------------------------------------------
// mux4way16_arbiter
//   Shares one WIDTH-bit output channel between four requesters using
//   round-robin (RR_MODE=1) or fixed a>b>c>d priority (RR_MODE=0). The
//   winning word is registered and offered on a valid/ready handshake.
//   Ports:
//     clk        in   1      rising-edge clock
//     rst_n      in   1      asynchronous active-low reset
//     req        in   4      level requests, req[0]=a .. req[3]=d
//     a,b,c,d    in   WIDTH  requester data
//     ack        out  4      one-hot, high in the cycle the word is captured
//     sel        out  2      index of the last granted requester
//     out        out  WIDTH  captured word
//     out_valid  out  1      out holds a word not yet accepted
//     out_ready  in   1      consumer accepts out when out_valid && out_ready
// ---------------------------------------------------------------------------
module mux4way16_arbiter
  import mux4way16_arbiter_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter bit RR_MODE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [3:0]       ack,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);

  state_t           state;
  state_t           state_next;
  logic [1:0]       ptr;
  logic [1:0]       winner;
  logic [1:0]       start_idx;
  logic [1:0]       idx;
  logic             found;
  logic             load;
  logic [WIDTH-1:0] mux_out;

  // Winner search: start just after the last grant (or at a in fixed mode),
  // walk upward with 2-bit wraparound and take the first active request.
  // With no request the winner is irrelevant because load is low.
  always_comb begin
    start_idx = RR_MODE ? (ptr + 2'd1) : REQ_A;
    winner    = start_idx;
    found     = 1'b0;
    idx       = 2'd0;
    for (int j = 0; j < 4; j++) begin
      idx = start_idx + 2'(j);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // A word is taken when someone is asking and the output slot is free or
  // being emptied this cycle. rst_n gates it so ack stays low during reset.
  always_comb begin
    load = rst_n && (|req) && ((state == IDLE) || out_ready);
    ack  = load ? onehot4(winner) : 4'b0000;
  end

  mux4way16 #(.WIDTH(WIDTH)) u_mux (
    .sel (winner),
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .out (mux_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a load always leaves the slot FULL; an accept with nothing
  // new to load empties it; a stalled consumer keeps it FULL.
  always_comb begin
    state_next = state;
    out_valid  = (state == FULL);
    case (state)
      IDLE: begin
        if (load) state_next = FULL;
      end
      FULL: begin
        if (load) begin
          state_next = FULL;
        end else if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output word, select and priority pointer only move on a load, so a
  // stalled consumer neither changes the data nor rotates priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
      sel <= SEL_RST;
      ptr <= PTR_RST;
    end else if (load) begin
      out <= mux_out;
      sel <= winner;
      ptr <= winner;
    end
  end

endmodule

// File: tb/tb_mux4way16_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux4way16_arbiter
//   Drives a round-robin and a fixed-priority instance with the same
//   directed stimulus. A behavioural model of both is compared on every
//   falling edge, and hand-computed literals pin the expected sequences.
// ---------------------------------------------------------------------------
module tb_mux4way16_arbiter;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [W-1:0] a, b, c, d;
  logic         out_ready;

  logic [3:0]   ack_rr, ack_fp;
  logic [1:0]   sel_rr, sel_fp;
  logic [W-1:0] out_rr, out_fp;
  logic         valid_rr, valid_fp;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;

  // Model state, index 0 = fixed priority, 1 = round robin.
  logic         m_valid [2] = '{1'b0, 1'b0};
  logic [W-1:0] m_out   [2] = '{16'h0, 16'h0};
  logic [1:0]   m_sel   [2] = '{2'd3, 2'd3};
  logic [1:0]   m_ptr   [2] = '{2'd3, 2'd3};

  mux4way16_arbiter #(.WIDTH(W), .RR_MODE(1'b1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .c(c), .d(d),
    .ack(ack_rr), .sel(sel_rr), .out(out_rr), .out_valid(valid_rr),
    .out_ready(out_ready)
  );

  mux4way16_arbiter #(.WIDTH(W), .RR_MODE(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .c(c), .d(d),
    .ack(ack_fp), .sel(sel_fp), .out(out_fp), .out_valid(valid_fp),
    .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Who wins under the arbitration rules: fixed mode takes the lowest
  // requester, round robin takes the first one after the last grant.
  function automatic int pickWinner(input int mode, input int p, input logic [3:0] r);
    if (mode == 0) begin
      for (int i = 0; i < 4; i++) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] dataOf(input int i);
    case (i)
      0:       return a;
      1:       return b;
      2:       return c;
      default: return d;
    endcase
  endfunction

  function automatic bit modelLoad(input int mode);
    return rst_n && (req != 4'b0000) && (!m_valid[mode] || out_ready);
  endfunction

  function automatic logic [3:0] modelAck(input int mode);
    if (!modelLoad(mode)) return 4'b0000;
    return 4'(1 << pickWinner(mode, int'(m_ptr[mode]), req));
  endfunction

  // Model update at each clock, cleared asynchronously by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < 2; m++) begin
        m_valid[m] <= 1'b0;
        m_out[m]   <= '0;
        m_sel[m]   <= 2'd3;
        m_ptr[m]   <= 2'd3;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (modelLoad(m)) begin
          m_valid[m] <= 1'b1;
          m_out[m]   <= dataOf(pickWinner(m, int'(m_ptr[m]), req));
          m_sel[m]   <= 2'(pickWinner(m, int'(m_ptr[m]), req));
          m_ptr[m]   <= 2'(pickWinner(m, int'(m_ptr[m]), req));
        end else if (m_valid[m] && out_ready) begin
          m_valid[m] <= 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every falling edge: both instances against the model.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("rr.ack",   16'(ack_rr),   16'(modelAck(1)));
      checkOutput("rr.valid", 16'(valid_rr), 16'(m_valid[1]));
      checkOutput("rr.out",   out_rr,        m_out[1]);
      checkOutput("rr.sel",   16'(sel_rr),   16'(m_sel[1]));
      checkOutput("fp.ack",   16'(ack_fp),   16'(modelAck(0)));
      checkOutput("fp.valid", 16'(valid_fp), 16'(m_valid[0]));
      checkOutput("fp.out",   out_fp,        m_out[0]);
      checkOutput("fp.sel",   16'(sel_fp),   16'(m_sel[0]));
    end
  end

  task automatic applyStimulus(input logic [3:0] r, input logic rdy);
    @(negedge clk);
    #1;
    req       = r;
    out_ready = rdy;
    #2;
  endtask

  task automatic pinRr(input string tag, input logic [3:0] eAck, input logic eValid,
                       input logic [W-1:0] eOut, input logic [1:0] eSel);
    checkOutput({tag, ".ack"},   16'(ack_rr),   16'(eAck));
    checkOutput({tag, ".valid"}, 16'(valid_rr), 16'(eValid));
    checkOutput({tag, ".out"},   out_rr,        eOut);
    checkOutput({tag, ".sel"},   16'(sel_rr),   16'(eSel));
  endtask

  task automatic pulseReset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    req   = 4'b0000;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req = 4'b1111;
    out_ready = 1'b0;
    a = 16'h1234; b = 16'h9876; c = 16'hAAAA; d = 16'h5555;
    repeat (2) @(negedge clk);
    checking = 1'b1;
    #3;
    $display("[TB] reset hold");
    pinRr("t1", 4'b0000, 1'b0, 16'h0000, 2'b11);
    checkOutput("t1.fp.ack", 16'(ack_fp), 16'h0000);

    $display("[TB] first grant");
    @(negedge clk); #1; rst_n = 1'b1; req = 4'b0001; #2;
    pinRr("t2a", 4'b0001, 1'b0, 16'h0000, 2'b11);
    applyStimulus(4'b0000, 1'b0);
    pinRr("t2b", 4'b0000, 1'b1, 16'h1234, 2'b00);

    $display("[TB] round robin rotation");
    pulseReset();
    applyStimulus(4'b1111, 1'b1); pinRr("t3a", 4'b0001, 1'b0, 16'h0000, 2'b11);
    applyStimulus(4'b1111, 1'b1); pinRr("t3b", 4'b0010, 1'b1, 16'h1234, 2'b00);
    applyStimulus(4'b1111, 1'b1); pinRr("t3c", 4'b0100, 1'b1, 16'h9876, 2'b01);
    applyStimulus(4'b1111, 1'b1); pinRr("t3d", 4'b1000, 1'b1, 16'hAAAA, 2'b10);
    applyStimulus(4'b1111, 1'b1); pinRr("t3e", 4'b0001, 1'b1, 16'h5555, 2'b11);
    applyStimulus(4'b0000, 1'b0); pinRr("t3f", 4'b0000, 1'b1, 16'h1234, 2'b00);

    $display("[TB] backpressure");
    applyStimulus(4'b0010, 1'b1); pinRr("t4a", 4'b0010, 1'b1, 16'h1234, 2'b00);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0100, 1'b0); pinRr("t4stall", 4'b0000, 1'b1, 16'h9876, 2'b01);
    end
    applyStimulus(4'b0100, 1'b1); pinRr("t4b", 4'b0100, 1'b1, 16'h9876, 2'b01);
    applyStimulus(4'b0000, 1'b0); pinRr("t4c", 4'b0000, 1'b1, 16'hAAAA, 2'b10);
    applyStimulus(4'b0000, 1'b1); pinRr("t4d", 4'b0000, 1'b1, 16'hAAAA, 2'b10);
    applyStimulus(4'b0000, 1'b0); pinRr("t4e", 4'b0000, 1'b0, 16'hAAAA, 2'b10);

    $display("[TB] reset mid-operation");
    applyStimulus(4'b1000, 1'b1); pinRr("t6a", 4'b1000, 1'b0, 16'hAAAA, 2'b10);
    applyStimulus(4'b0000, 1'b0); pinRr("t6b", 4'b0000, 1'b1, 16'h5555, 2'b11);
    @(posedge clk); #2; rst_n = 1'b0; #1;
    pinRr("t6c", 4'b0000, 1'b0, 16'h0000, 2'b11);
    @(negedge clk); #1; rst_n = 1'b1; req = 4'b1000; #2;
    pinRr("t6d", 4'b1000, 1'b0, 16'h0000, 2'b11);

    $display("[TB] fixed priority");
    pulseReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1010, 1'b1);
      checkOutput("t5.fp.ack", 16'(ack_fp), 16'h0002);
    end
    checkOutput("t5.fp.out", out_fp, 16'h9876);
    checkOutput("t5.fp.sel", 16'(sel_fp), 16'h0001);
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0000, 1'b0);

    @(negedge clk);
    checking = 1'b0;
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
